taxi_meter_core: RTL

- Parametrised fare/odometer engine for the taxi meter.
- Takes wheel pulses from the step-motor path, a 1 s tick from the divider, and per-tariff prices from the price-setting block.
- Produces binary distance and fee for the Binary BCD converters.
- Adds over the first generation: N selectable tariffs (latched per trip), saturating arithmetic with a sticky flag, a trip-done freeze state, and configurable widths and base distance.

---
 rtl/taxi_pkg.sv | 27 ++
 rtl/sat_adder.sv | 18 +
 rtl/taxi_meter_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/taxi_pkg.sv
// Shared types and helpers for the taxi meter fare/odometer engine.
// Holds FSM state codes and tariff slice extraction from flattened buses.
package taxi_pkg;

    localparam int STATE_W   = 3;
    localparam int MAX_BUS_W = 256;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Pull the w-bit field at position idx out of a flattened price bus.
    function automatic logic [31:0] tariff_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return 32'(bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones on carry out.
// Ports: a, b (W) in; sum (W) out; sat out, high when the add overflowed.
module sat_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign sat    = w_full[W];
    assign sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/taxi_meter_core.sv
// Taxi meter fare/odometer engine with per-trip tariff latch and saturation.
// Ports: clk_M, reset (async low), start/pause/waitL levels, tariff_sel,
//        base_fee/unit_fee/wait_fee flattened price buses, wheel_pulse,
//        sec_tick strobes; outputs distance, fee, state, fee_sat, trip_done.
module taxi_meter_core
    import taxi_pkg::*;
#(
    parameter int DIST_W          = 10,
    parameter int FEE_W           = 10,
    parameter int N_TARIFF        = 2,
    parameter int PULSES_PER_UNIT = 10,
    parameter int BASE_DIST       = 30,
    parameter int WAIT_SECS       = 60,
    localparam int TS_W = (N_TARIFF > 1) ? $clog2(N_TARIFF) : 1,
    localparam int PC_W = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1,
    localparam int SC_W = (WAIT_SECS > 1) ? $clog2(WAIT_SECS) : 1
) (
    input  logic                      clk_M,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      waitL,
    input  logic [TS_W-1:0]           tariff_sel,
    input  logic [N_TARIFF*FEE_W-1:0] base_fee,
    input  logic [N_TARIFF*FEE_W-1:0] unit_fee,
    input  logic [N_TARIFF*FEE_W-1:0] wait_fee,
    input  logic                      wheel_pulse,
    input  logic                      sec_tick,
    output logic [DIST_W-1:0]         distance,
    output logic [FEE_W-1:0]          fee,
    output logic [STATE_W-1:0]        state,
    output logic                      fee_sat,
    output logic                      trip_done
);

    state_t            r_state;
    state_t            w_next;
    logic              r_start_q;
    logic [TS_W-1:0]   r_tariff;
    logic [PC_W-1:0]   r_pulse_cnt;
    logic [SC_W-1:0]   r_sec_cnt;
    logic [DIST_W-1:0] r_dist;
    logic [FEE_W-1:0]  r_fee;
    logic              r_fee_sat;

    logic              w_start_rise;
    logic              w_start_fall;
    logic              w_pulse_ok;
    logic              w_pulse_wrap;
    logic              w_tick_ok;
    logic              w_tick_wrap;
    logic [DIST_W-1:0] w_dist_sum;
    logic              w_dist_ovf;
    logic              w_dist_step;
    logic              w_unit_chg;
    logic              w_wait_chg;
    logic              w_charge;
    logic [FEE_W-1:0]  w_base;
    logic [FEE_W-1:0]  w_unit;
    logic [FEE_W-1:0]  w_wait;
    logic [FEE_W-1:0]  w_addend;
    logic [FEE_W-1:0]  w_fee_sum;
    logic              w_fee_ovf;

    assign w_start_rise = start & ~r_start_q;
    assign w_start_fall = ~start & r_start_q;

    // Base fee follows the live selector; running charges use the latched one.
    assign w_base = FEE_W'(tariff_slice(MAX_BUS_W'(base_fee),
                                        int'(tariff_sel), FEE_W));
    assign w_unit = FEE_W'(tariff_slice(MAX_BUS_W'(unit_fee),
                                        int'(r_tariff), FEE_W));
    assign w_wait = FEE_W'(tariff_slice(MAX_BUS_W'(wait_fee),
                                        int'(r_tariff), FEE_W));

    // Counting qualifies on the pre-transition state; a start edge drops it.
    assign w_pulse_ok   = wheel_pulse && (r_state == S_RUN) && !w_start_rise;
    assign w_pulse_wrap = w_pulse_ok
                       && (r_pulse_cnt == PC_W'(PULSES_PER_UNIT - 1));
    assign w_tick_ok    = sec_tick && (r_state == S_WAIT) && !w_start_rise;
    assign w_tick_wrap  = w_tick_ok && (r_sec_cnt == SC_W'(WAIT_SECS - 1));

    sat_adder #(.W(DIST_W)) u_dist_add (
        .a   (r_dist),
        .b   (DIST_W'(1)),
        .sum (w_dist_sum),
        .sat (w_dist_ovf)
    );

    // Overflow on +1 means distance is already pinned at its maximum.
    assign w_dist_step = w_pulse_wrap && !w_dist_ovf;
    assign w_unit_chg  = w_dist_step && (w_dist_sum > DIST_W'(BASE_DIST));
    assign w_wait_chg  = w_tick_wrap;
    assign w_charge    = w_unit_chg || w_wait_chg;
    assign w_addend    = w_unit_chg ? w_unit : w_wait;

    sat_adder #(.W(FEE_W)) u_fee_add (
        .a   (r_fee),
        .b   (w_addend),
        .sum (w_fee_sum),
        .sat (w_fee_ovf)
    );

    always_ff @(posedge clk_M or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start_rise) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN, S_WAIT: begin
                    if (w_start_fall) w_next = S_DONE;
                    else if (pause)   w_next = S_PAUSE;
                    else if (waitL)   w_next = S_WAIT;
                    else              w_next = S_RUN;
                end
                S_PAUSE: begin
                    if (w_start_fall) w_next = S_DONE;
                    else if (!pause)  w_next = waitL ? S_WAIT : S_RUN;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_M or negedge reset) begin
        if (!reset) begin
            r_start_q   <= 1'b0;
            r_tariff    <= '0;
            r_pulse_cnt <= '0;
            r_sec_cnt   <= '0;
            r_dist      <= '0;
            r_fee       <= '0;
            r_fee_sat   <= 1'b0;
        end else begin
            r_start_q <= start;
            if (w_start_rise) begin
                r_tariff    <= tariff_sel;
                r_pulse_cnt <= '0;
                r_sec_cnt   <= '0;
                r_dist      <= '0;
                r_fee       <= w_base;
                r_fee_sat   <= 1'b0;
            end else begin
                if (w_pulse_ok)
                    r_pulse_cnt <= w_pulse_wrap ? '0 : r_pulse_cnt + PC_W'(1);
                if (w_tick_ok)
                    r_sec_cnt <= w_tick_wrap ? '0 : r_sec_cnt + SC_W'(1);
                if (w_dist_step)
                    r_dist <= w_dist_sum;
                if (w_charge) begin
                    r_fee <= w_fee_sum;
                    if (w_fee_ovf) r_fee_sat <= 1'b1;
                end
            end
        end
    end

    assign distance  = r_dist;
    assign fee       = r_fee;
    assign state     = r_state;
    assign fee_sat   = r_fee_sat;
    assign trip_done = (r_state == S_DONE);

endmodule
